// File: rtl/i2c_cmd_sequencer_if.sv
// i2c_cmd_sequencer_if: RAM port and I2C master handshake between the sequencer and its neighbours
interface i2c_cmd_sequencer_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic              ram_wr_en;
  logic [31:0]       ram_write;
  logic [3:0]        ram_byte;
  logic [31:0]       ram_read;
  logic [6:0]        i2c_slave_addr;
  logic [7:0]        i2c_write;
  logic [7:0]        i2c_read;
  logic              i2c_rw;
  logic              i2c_ena;
  logic              i2c_reset_n;
  logic              i2c_busy;
  logic              i2c_ack_error;
  modport master (
    output ram_addr, ram_rd_en, ram_wr_en, ram_write, ram_byte,
    output i2c_slave_addr, i2c_write, i2c_rw, i2c_ena, i2c_reset_n,
    input  ram_read, i2c_read, i2c_busy, i2c_ack_error
  );
  modport slave (
    input  ram_addr, ram_rd_en, ram_wr_en, ram_write, ram_byte,
    input  i2c_slave_addr, i2c_write, i2c_rw, i2c_ena, i2c_reset_n,
    output ram_read, i2c_read, i2c_busy, i2c_ack_error
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: runs a RAM-resident list of single-byte I2C commands on the I2C master
// and writes one {status, data} result word back to RAM per command.
module i2c_cmd_sequencer #(
  parameter int ADDR_W        = 32,
  parameter int MAX_CMDS      = 16,
  parameter int RD_LATENCY    = 1,
  parameter int TIMEOUT_CYC   = 65535,
  parameter int ABORT_ON_NACK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_cmd_base,
  input  logic [ADDR_W-1:0] i_res_base,
  i2c_cmd_sequencer_if.master bus,
  output logic              o_running,
  output logic              o_done,
  output logic              o_error,
  output logic [4:0]        o_cmd_index,
  output logic [7:0]        o_led
);
  localparam logic [2:0]  S_IDLE = 3'd0, S_FETCH = 3'd1, S_ISSUE = 3'd2, S_WAIT_LO = 3'd3, S_WB = 3'd4, S_END = 3'd5;
  localparam logic [15:0] TO       = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] LAT      = 16'(RD_LATENCY);
  localparam logic [4:0]  LAST_IDX = 5'(MAX_CMDS - 1);
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cmd_base, r_res_base;
  logic [16:0]       r_cmd;
  logic [7:0]        r_status, r_data;
  logic [15:0]       r_cnt;
  logic [4:0]        r_idx;
  logic              r_error, r_rst_n, r_rst_cnt;
  logic [ADDR_W-1:0] w_off;
  logic              w_stop, w_running;
  // r_cmd keeps only {last, rw, slave[6:0], byte[7:0]}; the reserved low bits are dropped
  assign w_off     = ADDR_W'(r_idx) << 2;
  assign w_stop    = r_cmd[16] || (r_idx == LAST_IDX) || r_status[1] || ((|r_status) && ABORT_ON_NACK != 0);
  assign w_running = (r_state != S_IDLE) && (r_state != S_END);
  assign bus.ram_addr       = (r_state == S_WB) ? r_res_base + w_off : (r_state == S_FETCH) ? r_cmd_base + w_off : '0;
  assign bus.ram_rd_en      = (r_state == S_FETCH) && (r_cnt == 16'd0);
  assign bus.ram_wr_en      = (r_state == S_WB);
  assign bus.ram_write      = (r_state == S_WB) ? {16'h0, r_status, r_data} : 32'h0;
  assign bus.ram_byte       = {4{r_state == S_WB}};
  assign bus.i2c_slave_addr = r_cmd[14:8];
  assign bus.i2c_write      = r_cmd[7:0];
  assign bus.i2c_rw         = r_cmd[15];
  assign bus.i2c_ena        = (r_state == S_ISSUE);
  assign bus.i2c_reset_n    = r_rst_n;
  assign o_running          = w_running;
  assign o_done             = (r_state == S_END);
  assign o_error            = r_error;
  assign o_cmd_index        = r_idx;
  assign o_led              = {r_error, w_running, 2'b00, r_idx[3:0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd_base <= '0;
      r_res_base <= '0;
      r_cmd      <= '0;
      r_status   <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_error    <= 1'b0;
      r_rst_n    <= 1'b0;
      r_rst_cnt  <= 1'b0;
    end else begin
      r_cnt     <= (&r_cnt) ? r_cnt : r_cnt + 16'd1;
      r_rst_n   <= r_rst_n | !r_rst_cnt;
      r_rst_cnt <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_cmd_base <= i_cmd_base;
          r_res_base <= i_res_base;
          r_error    <= 1'b0;
          r_idx      <= '0;
          r_cnt      <= '0;
          r_state    <= S_FETCH;
        end
        S_FETCH: if (r_cnt == LAT) begin
          r_cmd    <= bus.ram_read[31:15];
          r_status <= '0;
          r_data   <= '0;
          r_cnt    <= '0;
          r_state  <= S_ISSUE;
        end
        S_ISSUE: if (bus.i2c_busy) begin
          r_cnt   <= '0;
          r_state <= S_WAIT_LO;
        end else if (r_cnt >= TO) begin
          r_status  <= 8'h02;
          r_rst_n   <= 1'b0;
          r_rst_cnt <= 1'b1;
          r_state   <= S_WB;
        end
        S_WAIT_LO: if (!bus.i2c_busy) begin
          r_data   <= r_cmd[15] ? bus.i2c_read : 8'h00;
          r_status <= {7'h0, bus.i2c_ack_error};
          r_state  <= S_WB;
        end else if (r_cnt >= TO) begin
          r_status  <= 8'h02;
          r_rst_n   <= 1'b0;
          r_rst_cnt <= 1'b1;
          r_state   <= S_WB;
        end
        S_WB: begin
          r_error <= r_error | (|r_status);
          r_idx   <= w_stop ? r_idx : r_idx + 5'd1;
          r_cnt   <= '0;
          r_state <= w_stop ? S_END : S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: RAM and I2C master models around two sequencers (abort and continue on NACK)
module tb_i2c_cmd_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
  logic [31:0] cmd_base = '0, res_base = '0;
  always #5 clk = ~clk;
  i2c_cmd_sequencer_if #(.ADDR_W(32)) b0 ();
  i2c_cmd_sequencer_if #(.ADDR_W(32)) b1 ();
  logic run0, run1, done0, done1, err0, err1;
  logic [4:0] idx0, idx1;
  logic [7:0] led0, led1;
  i2c_cmd_sequencer #(.TIMEOUT_CYC(20), .ABORT_ON_NACK(1)) dut0 (
    .clk(clk), .rst(rst), .i_start(start & !sel), .i_cmd_base(cmd_base), .i_res_base(res_base), .bus(b0),
    .o_running(run0), .o_done(done0), .o_error(err0), .o_cmd_index(idx0), .o_led(led0));
  i2c_cmd_sequencer #(.TIMEOUT_CYC(20), .ABORT_ON_NACK(0)) dut1 (
    .clk(clk), .rst(rst), .i_start(start & sel), .i_cmd_base(cmd_base), .i_res_base(res_base), .bus(b1),
    .o_running(run1), .o_done(done1), .o_error(err1), .o_cmd_index(idx1), .o_led(led1));
  logic busy = 1'b0, ack = 1'b0;
  logic [7:0] rd = '0, rbyte = '0;
  logic [31:0] rdata = '0;
  logic [2:0] bcnt = '0;
  int nack_at = -1;
  bit never_busy = 1'b0;
  assign b0.ram_read = rdata; assign b0.i2c_read = rd; assign b0.i2c_busy = busy; assign b0.i2c_ack_error = ack;
  assign b1.ram_read = rdata; assign b1.i2c_read = rd; assign b1.i2c_busy = busy; assign b1.i2c_ack_error = ack;
  logic m_rd, m_wr, m_ena, m_rw, m_rstn, m_done, m_run, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [3:0] m_byte;
  logic [6:0] m_slave;
  logic [7:0] m_wbyte, m_led;
  logic [4:0] m_idx;
  assign m_rd    = sel ? b1.ram_rd_en      : b0.ram_rd_en;
  assign m_wr    = sel ? b1.ram_wr_en      : b0.ram_wr_en;
  assign m_ena   = sel ? b1.i2c_ena        : b0.i2c_ena;
  assign m_rw    = sel ? b1.i2c_rw         : b0.i2c_rw;
  assign m_rstn  = sel ? b1.i2c_reset_n    : b0.i2c_reset_n;
  assign m_addr  = sel ? b1.ram_addr       : b0.ram_addr;
  assign m_wdata = sel ? b1.ram_write      : b0.ram_write;
  assign m_byte  = sel ? b1.ram_byte       : b0.ram_byte;
  assign m_slave = sel ? b1.i2c_slave_addr : b0.i2c_slave_addr;
  assign m_wbyte = sel ? b1.i2c_write      : b0.i2c_write;
  assign m_done  = sel ? done1 : done0;
  assign m_run   = sel ? run1  : run0;
  assign m_err   = sel ? err1  : err0;
  assign m_idx   = sel ? idx1  : idx0;
  assign m_led   = sel ? led1  : led0;
  logic [31:0] mem [0:1023];
  logic [15:0] act_tx[$], exp_tx[$];
  logic [67:0] act_wr[$], exp_wr[$];
  logic [31:0] act_rd[$];
  int tot = 0, bad = 0;
  // RAM with one-cycle read latency, plus a master that goes busy for 4 cycles per request
  always @(posedge clk) begin
    if (m_rd) begin rdata <= mem[m_addr[11:2]]; act_rd.push_back(m_addr); end
    if (m_wr) act_wr.push_back({m_byte, m_addr, m_wdata});
    if (rst) begin busy <= 1'b0; bcnt <= '0; ack <= 1'b0; end
    else if (bcnt != 0) begin bcnt <= bcnt - 3'd1; if (bcnt == 3'd1) busy <= 1'b0; end
    else if (m_ena && !busy && !never_busy) begin
      busy <= 1'b1; bcnt <= 3'd4; ack <= (act_tx.size() == nack_at); rd <= rbyte;
      act_tx.push_back({m_rw, m_slave, m_wbyte});
    end
  end
  function automatic logic [31:0] mk(bit last, bit rw, logic [6:0] a, logic [7:0] d);
    return {last, rw, a, d, 15'h0};
  endfunction
  task automatic run(input logic s, input logic [31:0] cb, input logic [31:0] rb, input bit restart,
                     output int max_idx, output int ena_cyc, output int rstn_lo, output bit got_done);
    int cyc;
    sel = s; cmd_base = cb; res_base = rb;
    cyc = 0; max_idx = 0; ena_cyc = 0; rstn_lo = 0; got_done = 0;
    @(negedge clk); start = 1'b1;
    while (!got_done && cyc < 2000) begin
      @(negedge clk); cyc++;
      start = restart && cyc == 5;
      if (restart && cyc == 5) begin cmd_base = 32'h900; res_base = 32'h980; end
      if (int'(m_idx) > max_idx) max_idx = int'(m_idx);
      if (m_ena) ena_cyc++;
      if (!m_rstn) rstn_lo++;
      if (m_done) got_done = 1;
    end
    start = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    tot++; if ({m_ena, m_rd, m_wr, m_run, m_done, m_err, m_rstn} !== 7'b0) begin bad++; $display("FAIL reset ctl: got %b want 0", {m_ena, m_rd, m_wr, m_run, m_done, m_err, m_rstn}); end
    tot++; if ({m_addr, m_wdata, m_byte, m_led, m_idx} !== '0) begin bad++; $display("FAIL reset data: got %h want 0", {m_addr, m_wdata, m_byte, m_led, m_idx}); end
    rst = 1'b0;
    @(negedge clk);
    tot++; if (m_rstn !== 1'b1) begin bad++; $display("FAIL reset i2c_reset_n release: got %b want 1", m_rstn); end
  endtask
  task automatic test_write_list();
    int t0, w0, r0, mi, ec, rl; bit gd; logic [15:0] e16; logic [67:0] e68;
    mem[32'h100 >> 2] = mk(0, 0, 7'h54, 8'h12);
    mem[32'h104 >> 2] = mk(0, 0, 7'h54, 8'h34);
    mem[32'h108 >> 2] = mk(1, 0, 7'h54, 8'h56);
    mem[32'h900 >> 2] = mk(1, 0, 7'h11, 8'hEE);
    foreach (mem[i]) if (i == 0) exp_tx.push_back({1'b0, 7'h54, 8'h12});
    exp_tx.push_back({1'b0, 7'h54, 8'h34}); exp_tx.push_back({1'b0, 7'h54, 8'h56});
    for (int k = 0; k < 3; k++) exp_wr.push_back({4'hF, 32'h200 + 32'(4 * k), 32'h0});
    t0 = act_tx.size(); w0 = act_wr.size(); r0 = act_rd.size();
    run(0, 32'h100, 32'h200, 1, mi, ec, rl, gd);
    tot++; if (!gd) begin bad++; $display("FAIL write_list done: got 0 want 1"); end
    tot++; if (act_rd.size() - r0 != 3) begin bad++; $display("FAIL write_list fetches: got %0d want 3", act_rd.size() - r0); end
    tot++; if ({m_err, m_run, m_idx} !== {2'b00, 5'd2}) begin bad++; $display("FAIL write_list err/run/idx: got %b want 0000010", {m_err, m_run, m_idx}); end
    tot++; if (act_tx.size() - t0 != exp_tx.size()) begin bad++; $display("FAIL write_list tx count: got %0d want %0d", act_tx.size() - t0, exp_tx.size()); end
    for (int i = t0; exp_tx.size() > 0; i++) begin e16 = exp_tx.pop_front(); tot++; if (act_tx[i] !== e16) begin bad++; $display("FAIL write_list tx%0d: got %h want %h", i - t0, act_tx[i], e16); end end
    tot++; if (act_wr.size() - w0 != exp_wr.size()) begin bad++; $display("FAIL write_list wr count: got %0d want %0d", act_wr.size() - w0, exp_wr.size()); end
    for (int i = w0; exp_wr.size() > 0; i++) begin e68 = exp_wr.pop_front(); tot++; if (act_wr[i] !== e68) begin bad++; $display("FAIL write_list wr%0d: got %h want %h", i - w0, act_wr[i], e68); end end
  endtask
  task automatic test_read();
    int t0, w0, mi, ec, rl; bit gd; logic [15:0] e16; logic [67:0] e68;
    mem[32'h300 >> 2] = mk(1, 1, 7'h68, 8'h00);
    rbyte = 8'hA5;
    exp_tx.push_back({1'b1, 7'h68, 8'h00}); exp_wr.push_back({4'hF, 32'h400, 32'h000000A5});
    t0 = act_tx.size(); w0 = act_wr.size();
    run(0, 32'h300, 32'h400, 0, mi, ec, rl, gd);
    tot++; if (!gd || mi != 0 || m_idx !== 5'd0 || m_err !== 1'b0) begin bad++; $display("FAIL read done/idx/err: got %0d %0d %0d %b want 1 0 0 0", gd, mi, m_idx, m_err); end
    tot++; if (act_tx.size() - t0 != 1 || act_wr.size() - w0 != 1) begin bad++; $display("FAIL read counts: got %0d %0d want 1 1", act_tx.size() - t0, act_wr.size() - w0); end
    e16 = exp_tx.pop_front(); tot++; if (act_tx[t0] !== e16) begin bad++; $display("FAIL read tx: got %h want %h", act_tx[t0], e16); end
    e68 = exp_wr.pop_front(); tot++; if (act_wr[w0] !== e68) begin bad++; $display("FAIL read wr: got %h want %h", act_wr[w0], e68); end
    rbyte = 8'h00;
  endtask
  task automatic test_nack(input logic s);
    int t0, w0, r0, mi, ec, rl, n; bit gd; logic [67:0] e68;
    n = s ? 3 : 2;
    exp_wr.push_back({4'hF, 32'h500, 32'h0}); exp_wr.push_back({4'hF, 32'h504, 32'h100});
    if (s) exp_wr.push_back({4'hF, 32'h508, 32'h0});
    t0 = act_tx.size(); w0 = act_wr.size(); r0 = act_rd.size();
    nack_at = t0 + 1;
    run(s, 32'h100, 32'h500, 0, mi, ec, rl, gd);
    nack_at = -1;
    tot++; if (!gd || m_err !== 1'b1) begin bad++; $display("FAIL nack%0d done/err: got %0d %b want 1 1", s, gd, m_err); end
    tot++; if (m_led !== {1'b1, 1'b0, 2'b00, 4'(n - 1)}) begin bad++; $display("FAIL nack%0d led: got %h want %h", s, m_led, {1'b1, 1'b0, 2'b00, 4'(n - 1)}); end
    tot++; if (act_rd.size() - r0 != n || act_tx.size() - t0 != n) begin bad++; $display("FAIL nack%0d fetch/tx: got %0d %0d want %0d", s, act_rd.size() - r0, act_tx.size() - t0, n); end
    tot++; if (act_wr.size() - w0 != exp_wr.size()) begin bad++; $display("FAIL nack%0d wr count: got %0d want %0d", s, act_wr.size() - w0, exp_wr.size()); end
    for (int i = w0; exp_wr.size() > 0; i++) begin e68 = exp_wr.pop_front(); tot++; if (act_wr[i] !== e68) begin bad++; $display("FAIL nack%0d wr%0d: got %h want %h", s, i - w0, act_wr[i], e68); end end
  endtask
  task automatic test_timeout();
    int t0, w0, mi, ec, rl; bit gd; logic [67:0] e68;
    mem[32'h700 >> 2] = mk(1, 0, 7'h22, 8'h33);
    never_busy = 1'b1;
    exp_wr.push_back({4'hF, 32'h780, 32'h00000200});
    t0 = act_tx.size(); w0 = act_wr.size();
    run(0, 32'h700, 32'h780, 0, mi, ec, rl, gd);
    never_busy = 1'b0;
    tot++; if (!gd || m_err !== 1'b1) begin bad++; $display("FAIL timeout done/err: got %0d %b want 1 1", gd, m_err); end
    tot++; if (ec != 20) begin bad++; $display("FAIL timeout ena cycles: got %0d want 20", ec); end
    tot++; if (rl != 2) begin bad++; $display("FAIL timeout reset_n low cycles: got %0d want 2", rl); end
    tot++; if (act_tx.size() != t0 || act_wr.size() - w0 != 1) begin bad++; $display("FAIL timeout counts: got %0d %0d want 0 1", act_tx.size() - t0, act_wr.size() - w0); end
    e68 = exp_wr.pop_front(); tot++; if (act_wr[w0] !== e68) begin bad++; $display("FAIL timeout wr: got %h want %h", act_wr[w0], e68); end
  endtask
  task automatic test_max_cmds();
    int t0, w0, mi, ec, rl; bit gd; logic [15:0] e16; logic [67:0] e68;
    for (int k = 0; k < 20; k++) begin
      mem[(32'h800 >> 2) + k] = mk(0, 0, 7'(k), 8'(8'h40 + k));
      if (k < 16) begin exp_tx.push_back({1'b0, 7'(k), 8'(8'h40 + k)}); exp_wr.push_back({4'hF, 32'hA00 + 32'(4 * k), 32'h0}); end
    end
    t0 = act_tx.size(); w0 = act_wr.size();
    run(0, 32'h800, 32'hA00, 0, mi, ec, rl, gd);
    tot++; if (!gd || m_idx !== 5'd15 || m_err !== 1'b0) begin bad++; $display("FAIL max_cmds done/idx/err: got %0d %0d %b want 1 15 0", gd, m_idx, m_err); end
    tot++; if (act_tx.size() - t0 != 16 || act_wr.size() - w0 != 16) begin bad++; $display("FAIL max_cmds counts: got %0d %0d want 16 16", act_tx.size() - t0, act_wr.size() - w0); end
    for (int i = t0; exp_tx.size() > 0; i++) begin e16 = exp_tx.pop_front(); tot++; if (act_tx[i] !== e16) begin bad++; $display("FAIL max_cmds tx%0d: got %h want %h", i - t0, act_tx[i], e16); end end
    for (int i = w0; exp_wr.size() > 0; i++) begin e68 = exp_wr.pop_front(); tot++; if (act_wr[i] !== e68) begin bad++; $display("FAIL max_cmds wr%0d: got %h want %h", i - w0, act_wr[i], e68); end end
  endtask
  task automatic test_rst_mid();
    int w0, cyc; bit found, saw_done;
    mem[32'hB00 >> 2] = mk(1, 0, 7'h05, 8'h77);
    sel = 1'b0; cmd_base = 32'hB00; res_base = 32'hC00;
    w0 = act_wr.size(); found = 0; saw_done = 0; cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!found && cyc < 100) begin
      @(negedge clk); cyc++;
      if (m_done) saw_done = 1;
      found = busy && !m_ena && m_run;
    end
    tot++; if (!found) begin bad++; $display("FAIL rst_mid reach WAIT_LO: got 0 want 1"); end
    #1 rst = 1'b1;
    #1;
    tot++; if ({m_ena, m_run, m_rstn, m_wr} !== 4'b0) begin bad++; $display("FAIL rst_mid outputs: got %b want 0000", {m_ena, m_run, m_rstn, m_wr}); end
    repeat (3) begin @(negedge clk); if (m_done) saw_done = 1; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (m_done) saw_done = 1; end
    tot++; if (act_wr.size() != w0 || saw_done) begin bad++; $display("FAIL rst_mid no write/done: got %0d %0d want 0 0", act_wr.size() - w0, saw_done); end
    tot++; if (m_rstn !== 1'b1 || m_run !== 1'b0) begin bad++; $display("FAIL rst_mid recovery: got %b %b want 1 0", m_rstn, m_run); end
  endtask
  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    test_reset();
    test_write_list();
    test_read();
    test_nack(1'b0);
    test_nack(1'b1);
    test_timeout();
    test_max_cmds();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Parametrised successor to the RAM-to-I2C chaining block.
- Fetches a list of I2C command words from RAM starting at a programmable base, runs each one as a single-byte transaction on the existing I2C master (ena/busy/ack_error handshake), and writes a result word back to RAM per command.
- Adds what the earlier block lacked: start/done control, configurable list length and RAM read latency, a busy timeout, abort-on-NACK or continue mode, and per-command status.
- Sits between the RAM port and the I2C master; LEDs show progress.

Parameters:
- ADDR_W, 32, RAM address width
- MAX_CMDS, 16, hard limit on commands per run (list also ends on the last bit)
- RD_LATENCY, 1, cycles from ram_rd_en to valid ram_read (1..4)
- TIMEOUT_CYC, 65535, max cycles to wait on each i2c_busy edge
- ABORT_ON_NACK, 1, 1 = stop the run on ack_error; 0 = record it and continue

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; starts a run (ignored while running)
- cmd_base  in  ADDR_W  byte address of command 0; sampled on start
- res_base  in  ADDR_W  byte address of result 0; sampled on start
- ram_addr  out  ADDR_W  RAM byte address
- ram_rd_en  out  1  read strobe, one cycle
- ram_wr_en  out  1  write strobe, one cycle
- ram_write  out  32  write data
- ram_byte  out  4  byte enables for writes
- ram_read  in  32  read data
- i2c_slave_addr  out  7  to master
- i2c_write  out  8  write byte to master
- i2c_read  in  8  byte from master
- i2c_rw  out  1  1 = read
- i2c_ena  out  1  request to master
- i2c_reset_n  out  1  master reset, active low
- i2c_busy  in  1  master busy
- i2c_ack_error  in  1  master NACK flag
- running  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at the end of a run
- error  out  1  sticky; cleared on start
- cmd_index  out  5  index of the current command
- led  out  8  {error, running, 2'b0, cmd_index[3:0]}

Behaviour:
- Reset values (async on rst): all outputs 0 except i2c_reset_n = 0. Internal state goes to IDLE.
- i2c_reset_n is registered high on the first clk after rst deasserts.
- Command word format:
  - [31] last
  - [30] rw
  - [29:23] slave address
  - [22:15] write byte
  - [14:0] reserved, ignored
- Addressing:
  - Command k is read from cmd_base + 4k.
  - Result k is written to res_base + 4k.
  - Address sums wrap modulo 2^ADDR_W.
- Result word:
  - {16'h0, status[7:0], data[7:0]}.
  - data = i2c_read for reads, 0 for writes.
  - status bit0 = NACK, bit1 = timeout.
  - ram_byte = 4'b1111.
- State machine:
  - IDLE: wait for start. On start, latch bases, clear error, set cmd_index = 0, go to FETCH.
  - FETCH: pulse ram_rd_en with ram_addr = command address, then wait RD_LATENCY cycles. Capture ram_read and go to ISSUE.
  - ISSUE: drive the slave address, write byte and rw from the captured word. Assert i2c_ena and hold it until i2c_busy = 1 is sampled (go to WAIT_LO). If busy does not rise within TIMEOUT_CYC, go to WB with the timeout bit set.
  - WAIT_LO: deassert i2c_ena. Wait for i2c_busy = 0, then capture i2c_read and i2c_ack_error. If busy does not fall within TIMEOUT_CYC, set the timeout bit. Go to WB.
  - WB: pulse ram_wr_en with the result word. Any status bit set makes error = 1. Then:
    - go to END if the last bit was set, or cmd_index = MAX_CMDS-1, or (status != 0 and ABORT_ON_NACK), or there was a timeout;
    - otherwise increment cmd_index and go to FETCH.
  - END: pulse done for one cycle, drop running, go to IDLE.
- A timeout always aborts the run regardless of ABORT_ON_NACK. It also pulses i2c_reset_n low for 2 cycles to recover the master.
- start while running: ignored. start and rst together: rst wins.
- rst mid-transaction: everything returns to reset values immediately. No result is written and done is not pulsed.
- The timeout counter is 16 bits, saturating, and clears on entry to each wait.
- The write byte is driven even for reads. The master ignores it.

Test Plan:
- Write list (3 commands): cmd_base = 0x100 holds 0x2A_..., 0x2A_..., and a third with last = 1. Each is a write to slave address 0x54 with data 0x12, 0x34, 0x56. Master model acks -> 3 transactions with i2c_write = 0x12/0x34/0x56; results 0x00000000 at res_base = 0x200, 0x204, 0x208; done pulse; error = 0.
- Read: single command, rw = 1, address 0x68, last = 1; master returns 0xA5 -> result word 0x000000A5; cmd_index = 0 throughout.
- NACK with ABORT_ON_NACK = 1: NACK on command 1 of 3 -> result 1 = 0x00000100; command 2 is never fetched; error = 1; done pulses.
- NACK with ABORT_ON_NACK = 0: same list -> all 3 results written; error = 1.
- Timeout: TIMEOUT_CYC = 20 and busy never rises -> ena held for 20 cycles; result 0x00000200; i2c_reset_n low for 2 cycles; done pulses.
- MAX_CMDS limit and reset: a list with no last bit stops after 16 results. rst asserted during WAIT_LO -> i2c_ena = 0, running = 0 and i2c_reset_n = 0 immediately, with no write strobe.
